// File: rtl/auth_ctrl_pkg.sv
// Shared state encoding, default tick constants and the fail-counter helper
// for the authentication lockout controller.
package auth_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_READY   = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_SESSION = 2'd2,
        ST_LOCKOUT = 2'd3
    } auth_state_e;

    localparam int DEF_MAX_FAILS     = 3;
    localparam int DEF_LOCK_TICKS    = 10;
    localparam int DEF_ENTRY_TICKS   = 8;
    localparam int DEF_SESSION_TICKS = 15;

    // Saturating increment so the failure count can never wrap past the limit.
    function automatic logic [1:0] fail_inc(input logic [1:0] cnt, input logic [1:0] max_fails);
        logic [1:0] res;
        if (cnt >= max_fails) begin
            res = max_fails;
        end else begin
            res = cnt + 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// 4-bit load/decrement down counter; expire flags the tick that takes it
// from 1 to 0. Load has priority over decrement and suppresses expire.
module tick_timer
    import auth_ctrl_pkg::*;
(
    input  logic       clklento,
    input  logic       rst_oneshot,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] count,
    output logic       expire
);

    logic [3:0] count_r;
    logic [3:0] count_nxt_s;

    // Next count: load, else decrement without wrapping below zero.
    always_comb begin
        count_nxt_s = count_r;
        if (load) begin
            count_nxt_s = load_val;
        end else if (dec && (count_r != 4'd0)) begin
            count_nxt_s = count_r - 4'd1;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count register.
    always_ff @(posedge clklento or posedge rst_oneshot) begin
        if (rst_oneshot) begin
            count_r <= 4'd0;
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign count  = count_r;
    assign expire = dec & ~load & (count_r == 4'd1);

endmodule

// File: rtl/auth_lockout_ctrl.sv
// Keypad entry / session / lockout supervisor around the password checker.
// Define AUTH_SESSION_TIMEOUT_EN to let an idle unlocked session expire.
module auth_lockout_ctrl
    import auth_ctrl_pkg::*;
#(
    parameter int MAX_FAILS     = DEF_MAX_FAILS,
    parameter int LOCK_TICKS    = DEF_LOCK_TICKS,
    parameter int ENTRY_TICKS   = DEF_ENTRY_TICKS,
    parameter int SESSION_TICKS = DEF_SESSION_TICKS
) (
    input  logic       clklento,
    input  logic       rst_oneshot,
    input  logic [9:0] key_pulse,
    input  logic       unlock_ok,
    input  logic       unlock_err,
    output logic [9:0] key_gate,
    output logic       checker_clr,
    output logic       arm_enable,
    output logic       locked_out,
    output logic [1:0] fail_cnt,
    output logic [3:0] lock_remain
);

    if ((MAX_FAILS < 1) || (MAX_FAILS > 3) || (LOCK_TICKS < 1) || (LOCK_TICKS > 15) ||
        (ENTRY_TICKS < 1) || (ENTRY_TICKS > 15) || (SESSION_TICKS < 1) || (SESSION_TICKS > 15)) begin : g_param_range
        $error("auth_lockout_ctrl: parameter out of range");
    end

    localparam logic [1:0] MAX_FAILS_C  = 2'(MAX_FAILS);
    localparam logic [3:0] LOCK_LOAD_C  = 4'(LOCK_TICKS);
    localparam logic [3:0] ENTRY_LOAD_C = 4'(ENTRY_TICKS);

    auth_state_e state_r;
    auth_state_e next_state_s;
    logic [1:0]  fail_cnt_r;
    logic [1:0]  fail_cnt_nxt_s;
    logic [1:0]  fail_inc_s;
    logic        checker_clr_r;
    logic        arm_enable_r;
    logic        locked_out_r;
    logic        clr_set_s;
    logic        key_any_s;

    logic        entry_load_s;
    logic        entry_dec_s;
    logic [3:0]  entry_cnt_s;
    logic        entry_exp_s;
    logic        lock_load_s;
    logic        lock_dec_s;
    logic [3:0]  lock_cnt_s;
    logic        lock_exp_s;
    logic        sess_exp_s;

    assign key_any_s  = (key_pulse != 10'd0);
    assign fail_inc_s = fail_inc(fail_cnt_r, MAX_FAILS_C);

    assign entry_load_s = key_any_s && ((state_r == ST_READY) || (state_r == ST_ENTRY));
    assign entry_dec_s  = (state_r == ST_ENTRY) && (entry_cnt_s != 4'd0);
    assign lock_load_s  = (state_r == ST_ENTRY) && unlock_err && (fail_inc_s == MAX_FAILS_C);
    assign lock_dec_s   = (state_r == ST_LOCKOUT) && (lock_cnt_s != 4'd0);

    tick_timer u_entry_timer (
        .clklento    (clklento),
        .rst_oneshot (rst_oneshot),
        .load        (entry_load_s),
        .load_val    (ENTRY_LOAD_C),
        .dec         (entry_dec_s),
        .count       (entry_cnt_s),
        .expire      (entry_exp_s)
    );

    tick_timer u_lock_timer (
        .clklento    (clklento),
        .rst_oneshot (rst_oneshot),
        .load        (lock_load_s),
        .load_val    (LOCK_LOAD_C),
        .dec         (lock_dec_s),
        .count       (lock_cnt_s),
        .expire      (lock_exp_s)
    );

`ifdef AUTH_SESSION_TIMEOUT_EN
    localparam logic [3:0] SESSION_LOAD_C = 4'(SESSION_TICKS);

    logic       sess_load_s;
    logic       sess_dec_s;
    logic [3:0] sess_cnt_s;

    // Any key while unlocked counts as activity and restarts the idle window.
    assign sess_load_s = ((state_r == ST_ENTRY) && unlock_ok && !unlock_err) ||
                         ((state_r == ST_SESSION) && key_any_s);
    assign sess_dec_s  = (state_r == ST_SESSION) && (sess_cnt_s != 4'd0);

    tick_timer u_session_timer (
        .clklento    (clklento),
        .rst_oneshot (rst_oneshot),
        .load        (sess_load_s),
        .load_val    (SESSION_LOAD_C),
        .dec         (sess_dec_s),
        .count       (sess_cnt_s),
        .expire      (sess_exp_s)
    );
`else
    assign sess_exp_s = 1'b0;
`endif

    // Next-state and fail-count decisions; a simultaneous ok/err is a failure.
    always_comb begin
        next_state_s   = state_r;
        fail_cnt_nxt_s = fail_cnt_r;
        case (state_r)
            ST_READY: begin
                if (key_any_s) begin
                    next_state_s = ST_ENTRY;
                end else begin
                    next_state_s = ST_READY;
                end
            end
            ST_ENTRY: begin
                if (unlock_err) begin
                    fail_cnt_nxt_s = fail_inc_s;
                    if (fail_inc_s == MAX_FAILS_C) begin
                        next_state_s = ST_LOCKOUT;
                    end else begin
                        next_state_s = ST_READY;
                    end
                end else if (unlock_ok) begin
                    next_state_s   = ST_SESSION;
                    fail_cnt_nxt_s = 2'd0;
                end else if (entry_exp_s) begin
                    next_state_s = ST_READY;
                end else begin
                    next_state_s = ST_ENTRY;
                end
            end
            ST_SESSION: begin
                if (sess_exp_s) begin
                    next_state_s = ST_READY;
                end else begin
                    next_state_s = ST_SESSION;
                end
            end
            ST_LOCKOUT: begin
                if (lock_exp_s) begin
                    next_state_s   = ST_READY;
                    fail_cnt_nxt_s = 2'd0;
                end else begin
                    next_state_s = ST_LOCKOUT;
                end
            end
            default: begin
                next_state_s   = ST_READY;
                fail_cnt_nxt_s = 2'd0;
            end
        endcase
    end

    assign clr_set_s = (next_state_s != state_r) &&
                       ((next_state_s == ST_READY) || (next_state_s == ST_LOCKOUT));

    // State, fail count and registered status outputs.
    always_ff @(posedge clklento or posedge rst_oneshot) begin
        if (rst_oneshot) begin
            state_r       <= ST_READY;
            fail_cnt_r    <= 2'd0;
            checker_clr_r <= 1'b0;
            arm_enable_r  <= 1'b0;
            locked_out_r  <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            fail_cnt_r    <= fail_cnt_nxt_s;
            checker_clr_r <= clr_set_s;
            arm_enable_r  <= (next_state_s == ST_SESSION);
            locked_out_r  <= (next_state_s == ST_LOCKOUT);
        end
    end

    assign key_gate    = ((state_r == ST_READY) || (state_r == ST_ENTRY)) ? key_pulse : 10'd0;
    assign checker_clr = checker_clr_r;
    assign arm_enable  = arm_enable_r;
    assign locked_out  = locked_out_r;
    assign fail_cnt    = fail_cnt_r;
    assign lock_remain = lock_cnt_s;

endmodule
